// File: rtl/nn_avalon_pkg.sv
// rtl/nn_avalon_pkg.sv - shared types, CSR bit indices and address-map helpers
package nn_avalon_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY      = 2'b00,
        RESP_SLVERR    = 2'b10,
        RESP_DECODEERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WBURST,
        S_RBURST,
        S_WRESP
    } state_t;

    typedef enum logic [2:0] {
        RGN_PIXEL,
        RGN_WEIGHT,
        RGN_RESULT,
        RGN_CTRL,
        RGN_STATUS,
        RGN_NONE
    } region_t;

    localparam int CTRL_CLEAR_BIT = 0;
    localparam int CTRL_START_BIT = 1;
    localparam int CTRL_IRQEN_BIT = 2;
    localparam int STAT_DONE_BIT  = 0;
    localparam int STAT_OVF_BIT   = 1;

    // Number of bus words holding the packed pixel array.
    function automatic int calc_pix_words(input int data_w, input int pixel_w, input int pixel_depth);
        return pixel_depth / (data_w / pixel_w);
    endfunction

    function automatic int calc_weight_base(input int data_w, input int pixel_w, input int pixel_depth);
        return calc_pix_words(data_w, pixel_w, pixel_depth);
    endfunction

    function automatic int calc_result_base(input int data_w, input int pixel_w, input int pixel_depth,
                                            input int weight_depth);
        return calc_weight_base(data_w, pixel_w, pixel_depth) + weight_depth;
    endfunction

    function automatic int calc_ctrl_addr(input int data_w, input int pixel_w, input int pixel_depth,
                                          input int weight_depth, input int result_count);
        return calc_result_base(data_w, pixel_w, pixel_depth, weight_depth) + result_count;
    endfunction

    // Error severity is ordered by encoding: OKAY < SLVERR < DECODEERR.
    function automatic resp_t worst_resp(input resp_t a, input resp_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nn_avalon_csr.sv
// rtl/nn_avalon_csr.sv - CONTROL/STATUS registers, W1C status, command pulses and irq
module nn_avalon_csr
    import nn_avalon_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ctrl_we_i,
    input  logic       status_we_i,
    input  logic [2:0] wdata_i,
    input  logic       done_calc_i,
    input  logic       overflow_i,
    output logic       irq_en_o,
    output logic       done_o,
    output logic       ovf_o,
    output logic       start_calc_o,
    output logic       clear_data_o,
    output logic       irq_o
);

    logic irq_en_q, irq_en_d;
    logic done_q, done_d;
    logic ovf_q, ovf_d;
    logic done_prev_q, ovf_prev_q;
    logic start_q, start_d;
    logic clear_q, clear_d;
    logic irq_q, irq_d;
    logic done_rise, ovf_rise;

    // Next-state: edge detect the core levels; a new edge beats a same-cycle W1C.
    always_comb begin
        done_rise = done_calc_i & ~done_prev_q;
        ovf_rise  = overflow_i & ~ovf_prev_q;
        irq_en_d  = ctrl_we_i ? wdata_i[CTRL_IRQEN_BIT] : irq_en_q;
        start_d   = ctrl_we_i & wdata_i[CTRL_START_BIT];
        clear_d   = ctrl_we_i & wdata_i[CTRL_CLEAR_BIT];
        done_d    = done_rise | (done_q & ~(status_we_i & wdata_i[STAT_DONE_BIT]));
        ovf_d     = ovf_rise  | (ovf_q  & ~(status_we_i & wdata_i[STAT_OVF_BIT]));
        irq_d     = irq_en_q & done_q;
    end

    // CSR state, edge history and registered pulse/irq outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            done_prev_q <= 1'b0;
            ovf_prev_q  <= 1'b0;
            start_q     <= 1'b0;
            clear_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            done_prev_q <= done_calc_i;
            ovf_prev_q  <= overflow_i;
            start_q     <= start_d;
            clear_q     <= clear_d;
            irq_q       <= irq_d;
        end
    end

    assign irq_en_o     = irq_en_q;
    assign done_o       = done_q;
    assign ovf_o        = ovf_q;
    assign start_calc_o = start_q;
    assign clear_data_o = clear_q;
    assign irq_o        = irq_q;

endmodule

// File: rtl/avalon_burst_slave.sv
// rtl/avalon_burst_slave.sv - Avalon-MM burst slave: FSM, address decode, burst counters
module avalon_burst_slave
    import nn_avalon_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 13,
    parameter int BURST_W      = 10,
    parameter int PIXEL_W      = 16,
    parameter int PIXEL_DEPTH  = 784,
    parameter int WEIGHT_DEPTH = 3920,
    parameter int RESULT_COUNT = 10,
    parameter int RESULT_W     = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            read_i,
    input  logic                            write_i,
    input  logic [ADDR_W-1:0]               address_i,
    input  logic [BURST_W-1:0]              burstcount_i,
    input  logic [DATA_W-1:0]               writedata_i,
    output logic                            waitrequest_o,
    output logic [DATA_W-1:0]               readdata_o,
    output logic                            readdatavalid_o,
    output logic                            writeresponsevalid_o,
    output logic [1:0]                      response_o,
    output logic                            pixel_we_o,
    output logic [$clog2(PIXEL_DEPTH)-1:0]  pixel_addr_o,
    output logic [DATA_W-1:0]               pixel_wdata_o,
    output logic                            weight_we_o,
    output logic [$clog2(WEIGHT_DEPTH)-1:0] weight_addr_o,
    output logic [DATA_W-1:0]               weight_wdata_o,
    output logic [$clog2(RESULT_COUNT)-1:0] result_addr_o,
    input  logic [RESULT_W-1:0]             result_data_i,
    input  logic                            done_calc_i,
    input  logic                            overflow_i,
    output logic                            start_calc_o,
    output logic                            clear_data_o,
    output logic                            irq_o
);

    localparam int PIX_PER_WORD = DATA_W / PIXEL_W;
    localparam int WEIGHT_BASE  = calc_weight_base(DATA_W, PIXEL_W, PIXEL_DEPTH);
    localparam int RESULT_BASE  = calc_result_base(DATA_W, PIXEL_W, PIXEL_DEPTH, WEIGHT_DEPTH);
    localparam int CTRL_ADDR    = calc_ctrl_addr(DATA_W, PIXEL_W, PIXEL_DEPTH, WEIGHT_DEPTH, RESULT_COUNT);
    localparam int STATUS_ADDR  = CTRL_ADDR + 1;
    // One extra bit so a burst running past the top of the map never wraps back into it.
    localparam int AW   = ADDR_W + 1;
    localparam int PA_W = $clog2(PIXEL_DEPTH);
    localparam int WA_W = $clog2(WEIGHT_DEPTH);
    localparam int RA_W = $clog2(RESULT_COUNT);

    state_t             state_q;
    logic [AW-1:0]      addr_q;
    logic [BURST_W-1:0] cnt_q;
    resp_t              err_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               rvalid_q;
    logic               wrvalid_q;
    resp_t              resp_q;

    logic [BURST_W-1:0] eff_count;
    logic [AW-1:0]      beat_addr;
    logic               wr_beat;
    logic               rd_beat;
    region_t            region;
    resp_t              wr_err;
    resp_t              rd_err;
    logic [DATA_W-1:0]  rd_data;
    logic               ctrl_we;
    logic               status_we;
    logic               irq_en;
    logic               st_done;
    logic               st_ovf;

    assign eff_count = (burstcount_i == '0) ? BURST_W'(1) : burstcount_i;

    // Pick the address of the beat handled this cycle; nothing is accepted while in reset.
    always_comb begin
        wr_beat   = 1'b0;
        rd_beat   = 1'b0;
        beat_addr = addr_q;
        if (!rst_i) begin
            case (state_q)
                S_IDLE: begin
                    if (write_i) begin
                        wr_beat   = 1'b1;
                        beat_addr = {1'b0, address_i};
                    end
                end
                S_WBURST: wr_beat = write_i;
                S_RBURST: rd_beat = 1'b1;
                default: ;
            endcase
        end
    end

    // Decode the beat address into a region of the contiguous map.
    always_comb begin
        region = RGN_NONE;
        if (beat_addr < AW'(WEIGHT_BASE))       region = RGN_PIXEL;
        else if (beat_addr < AW'(RESULT_BASE))  region = RGN_WEIGHT;
        else if (beat_addr < AW'(CTRL_ADDR))    region = RGN_RESULT;
        else if (beat_addr == AW'(CTRL_ADDR))   region = RGN_CTRL;
        else if (beat_addr == AW'(STATUS_ADDR)) region = RGN_STATUS;
    end

    // Per-beat response and read data by region; STATUS takes W1C writes.
    always_comb begin
        wr_err  = RESP_OKAY;
        rd_err  = RESP_OKAY;
        rd_data = '0;
        case (region)
            RGN_PIXEL, RGN_WEIGHT: rd_err = RESP_SLVERR;
            RGN_RESULT: begin
                wr_err  = RESP_SLVERR;
                rd_data = DATA_W'(result_data_i);
            end
            RGN_CTRL:   rd_data = DATA_W'({irq_en, 2'b00});
            RGN_STATUS: rd_data = DATA_W'({st_ovf, st_done});
            default: begin
                wr_err = RESP_DECODEERR;
                rd_err = RESP_DECODEERR;
            end
        endcase
    end

    // Memory-side strobes follow the accepted beat combinationally; idle values are zero.
    always_comb begin
        pixel_we_o     = wr_beat && (region == RGN_PIXEL);
        weight_we_o    = wr_beat && (region == RGN_WEIGHT);
        ctrl_we        = wr_beat && (region == RGN_CTRL);
        status_we      = wr_beat && (region == RGN_STATUS);
        pixel_addr_o   = pixel_we_o ? PA_W'(32'(beat_addr) * PIX_PER_WORD) : '0;
        pixel_wdata_o  = pixel_we_o ? writedata_i : '0;
        weight_addr_o  = weight_we_o ? WA_W'(32'(beat_addr) - WEIGHT_BASE) : '0;
        weight_wdata_o = weight_we_o ? writedata_i : '0;
        result_addr_o  = (rd_beat && (region == RGN_RESULT)) ? RA_W'(32'(beat_addr) - RESULT_BASE) : '0;
    end

    // Burst FSM with address/count tracking and registered read/response returns.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            err_q     <= RESP_OKAY;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            wrvalid_q <= 1'b0;
            resp_q    <= RESP_OKAY;
        end else begin
            rvalid_q  <= 1'b0;
            wrvalid_q <= 1'b0;
            resp_q    <= RESP_OKAY;
            rdata_q   <= '0;
            case (state_q)
                S_IDLE: begin
                    if (write_i) begin
                        addr_q <= beat_addr + AW'(1);
                        cnt_q  <= eff_count - BURST_W'(1);
                        err_q  <= wr_err;
                        if (eff_count == BURST_W'(1)) begin
                            state_q   <= S_WRESP;
                            wrvalid_q <= 1'b1;
                            resp_q    <= wr_err;
                        end else begin
                            state_q <= S_WBURST;
                        end
                    end else if (read_i) begin
                        addr_q  <= {1'b0, address_i};
                        cnt_q   <= eff_count;
                        state_q <= S_RBURST;
                    end
                end
                S_WBURST: begin
                    if (write_i) begin
                        addr_q <= addr_q + AW'(1);
                        cnt_q  <= cnt_q - BURST_W'(1);
                        err_q  <= worst_resp(err_q, wr_err);
                        if (cnt_q == BURST_W'(1)) begin
                            state_q   <= S_WRESP;
                            wrvalid_q <= 1'b1;
                            resp_q    <= worst_resp(err_q, wr_err);
                        end
                    end
                end
                S_RBURST: begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= rd_data;
                    resp_q   <= rd_err;
                    addr_q   <= addr_q + AW'(1);
                    cnt_q    <= cnt_q - BURST_W'(1);
                    if (cnt_q == BURST_W'(1)) begin
                        state_q <= S_IDLE;
                    end
                end
                S_WRESP: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Stall the host while read beats are issued and while the write response is returned.
    assign waitrequest_o        = rst_i || (state_q == S_RBURST) || (state_q == S_WRESP);
    assign readdata_o           = rdata_q;
    assign readdatavalid_o      = rvalid_q;
    assign writeresponsevalid_o = wrvalid_q;
    assign response_o           = resp_q;

    nn_avalon_csr u_csr (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ctrl_we_i    (ctrl_we),
        .status_we_i  (status_we),
        .wdata_i      (writedata_i[2:0]),
        .done_calc_i  (done_calc_i),
        .overflow_i   (overflow_i),
        .irq_en_o     (irq_en),
        .done_o       (st_done),
        .ovf_o        (st_ovf),
        .start_calc_o (start_calc_o),
        .clear_data_o (clear_data_o),
        .irq_o        (irq_o)
    );

endmodule

// File: tb/tb_avalon_burst_slave.sv
// tb/tb_avalon_burst_slave.sv - scoreboard bench for avalon_burst_slave
module tb_avalon_burst_slave;

    localparam int RB   = 4312;
    localparam int CTRL = 4322;
    localparam int STAT = 4323;

    logic        clk = 1'b0;
    logic        rst;
    logic        read, write;
    logic [12:0] address;
    logic [9:0]  burstcount;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid, writeresponsevalid;
    logic [1:0]  response;
    logic        pixel_we, weight_we;
    logic [9:0]  pixel_addr;
    logic [11:0] weight_addr;
    logic [31:0] pixel_wdata, weight_wdata;
    logic [3:0]  result_addr;
    logic [15:0] result_data;
    logic        done_calc, overflow, start_calc, clear_data, irq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { int kind; int addr; logic [31:0] data; } strobe_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } rd_t;
    strobe_t    sq[$];
    rd_t        rq[$];
    logic [1:0] wq[$];
    strobe_t    mon_s;
    rd_t        mon_r;
    logic [1:0] mon_w;
    logic [31:0] wbuf[8];

    always #5 clk = ~clk;

    assign result_data = 16'(result_addr * 3);

    avalon_burst_slave dut (
        .clk_i(clk), .rst_i(rst), .read_i(read), .write_i(write),
        .address_i(address), .burstcount_i(burstcount), .writedata_i(writedata),
        .waitrequest_o(waitrequest), .readdata_o(readdata), .readdatavalid_o(readdatavalid),
        .writeresponsevalid_o(writeresponsevalid), .response_o(response),
        .pixel_we_o(pixel_we), .pixel_addr_o(pixel_addr), .pixel_wdata_o(pixel_wdata),
        .weight_we_o(weight_we), .weight_addr_o(weight_addr), .weight_wdata_o(weight_wdata),
        .result_addr_o(result_addr), .result_data_i(result_data),
        .done_calc_i(done_calc), .overflow_i(overflow),
        .start_calc_o(start_calc), .clear_data_o(clear_data), .irq_o(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_strobe(input int kind, input int addr, input logic [31:0] data);
        strobe_t s;
        s.kind = kind; s.addr = addr; s.data = data;
        sq.push_back(s);
    endtask

    task automatic exp_read(input logic [31:0] data, input logic [1:0] resp);
        rd_t r;
        r.data = data; r.resp = resp;
        rq.push_back(r);
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe or a response.
    always @(negedge clk) begin
        if (pixel_we || weight_we) begin
            if (sq.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_strobe: pixel_we=%0b weight_we=%0b required none", pixel_we, weight_we);
            end else begin
                mon_s = sq.pop_front();
                chk("strobe_kind", {31'b0, weight_we}, mon_s.kind);
                chk("strobe_addr", weight_we ? 32'(weight_addr) : 32'(pixel_addr), mon_s.addr);
                chk("strobe_data", weight_we ? weight_wdata : pixel_wdata, mon_s.data);
            end
        end
        if (readdatavalid) begin
            if (rq.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_readdatavalid: data=%0h required none", readdata);
            end else begin
                mon_r = rq.pop_front();
                chk("readdata", readdata, mon_r.data);
                chk("read_resp", 32'(response), 32'(mon_r.resp));
            end
        end
        if (writeresponsevalid) begin
            if (wq.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_wresp: resp=%0b required none", response);
            end else begin
                mon_w = wq.pop_front();
                chk("write_resp", 32'(response), 32'(mon_w));
            end
        end
    end

    task automatic do_write(input int addr, input int n, input int gap_at, input bit with_done);
        @(posedge clk); #1;
        write = 1'b1; address = addr[12:0]; burstcount = n[9:0]; writedata = wbuf[0];
        if (with_done) done_calc = 1'b1;
        for (int i = 1; i < n; i++) begin
            @(posedge clk); #1;
            if (i == gap_at) begin
                write = 1'b0;
                @(posedge clk); #1;
                write = 1'b1;
            end
            writedata = wbuf[i];
        end
        @(posedge clk); #1;
        write = 1'b0; done_calc = 1'b0;
        @(negedge clk);
        chk("wresp_timing", {31'b0, writeresponsevalid}, 1);
    endtask

    task automatic do_read(input int addr, input int n);
        int cnt = 0;
        int guard = 0;
        @(posedge clk); #1;
        read = 1'b1; address = addr[12:0]; burstcount = n[9:0];
        @(posedge clk); #1;
        read = 1'b0;
        @(negedge clk);
        while (waitrequest && guard < 200) begin
            cnt++; guard++;
            @(negedge clk);
        end
        chk("waitrequest_cycles", cnt, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst = 1'b1; read = 1'b0; write = 1'b0; address = '0; burstcount = '0;
        writedata = '0; done_calc = 1'b0; overflow = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_waitrequest", {31'b0, waitrequest}, 1);
        chk("rst_rdvalid", {31'b0, readdatavalid}, 0);
        chk("rst_wrvalid", {31'b0, writeresponsevalid}, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        chk("rst_pulses", {30'b0, start_calc, clear_data}, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("idle_waitrequest", {31'b0, waitrequest}, 0);

        // Pixel burst with an idle cycle between beats 2 and 3.
        wbuf[0] = 32'hAAAA_0001; wbuf[1] = 32'hBBBB_0002; wbuf[2] = 32'hCCCC_0003;
        exp_strobe(0, 10, 32'hAAAA_0001);
        exp_strobe(0, 12, 32'hBBBB_0002);
        exp_strobe(0, 14, 32'hCCCC_0003);
        wq.push_back(2'b00);
        do_write(5, 3, 2, 1'b0);

        // Weight top edge running into the result region.
        wbuf[0] = 32'hDDDD_0004; wbuf[1] = 32'hEEEE_0005; wbuf[2] = 32'hFFFF_0006;
        exp_strobe(1, 3918, 32'hDDDD_0004);
        exp_strobe(1, 3919, 32'hEEEE_0005);
        wq.push_back(2'b10);
        do_write(4310, 3, -1, 1'b0);

        // Full result region read.
        for (int i = 0; i < 10; i++) exp_read(32'(i * 3), 2'b00);
        do_read(RB, 10);

        // Write-only region read.
        exp_read(32'h0, 2'b10);
        do_read(0, 1);

        // Read past the top of the map.
        exp_read(32'd27, 2'b00);
        exp_read(32'h0, 2'b00);
        exp_read(32'h0, 2'b00);
        exp_read(32'h0, 2'b11);
        do_read(4321, 4);

        // Write burst covering STATUS and the unmapped word above it.
        wbuf[0] = 32'h0; wbuf[1] = 32'h0;
        wq.push_back(2'b11);
        do_write(STAT, 2, -1, 1'b0);

        // CONTROL self-clearing pulses.
        wbuf[0] = 32'h3;
        wq.push_back(2'b00);
        do_write(CTRL, 1, -1, 1'b0);
        chk("pulse_high", {30'b0, start_calc, clear_data}, 32'h3);
        @(negedge clk);
        chk("pulse_low", {30'b0, start_calc, clear_data}, 32'h0);
        exp_read(32'h0, 2'b00);
        do_read(CTRL, 1);

        // irq enable, done edge, W1C.
        wbuf[0] = 32'h4;
        wq.push_back(2'b00);
        do_write(CTRL, 1, -1, 1'b0);
        @(posedge clk); #1; done_calc = 1'b1;
        @(negedge clk);
        chk("irq_c0", {31'b0, irq}, 0);
        @(posedge clk); #1; done_calc = 1'b0;
        @(negedge clk);
        chk("irq_c1", {31'b0, irq}, 0);
        @(negedge clk);
        chk("irq_c2", {31'b0, irq}, 1);
        wbuf[0] = 32'h1;
        wq.push_back(2'b00);
        do_write(STAT, 1, -1, 1'b0);
        @(negedge clk);
        chk("irq_after_w1c", {31'b0, irq}, 0);
        exp_read(32'h0, 2'b00);
        do_read(STAT, 1);
        wq.push_back(2'b00);
        do_write(STAT, 1, -1, 1'b1);
        @(posedge clk); #1; overflow = 1'b1;
        @(posedge clk); #1; overflow = 1'b0;
        exp_read(32'h3, 2'b00);
        do_read(STAT, 1);
        chk("irq_set_wins", {31'b0, irq}, 1);
        exp_read(32'h4, 2'b00);
        do_read(CTRL, 1);

        // Reset in the middle of an 8-beat read after 3 beats have returned.
        exp_read(32'd0, 2'b00);
        exp_read(32'd3, 2'b00);
        exp_read(32'd6, 2'b00);
        @(posedge clk); #1;
        read = 1'b1; address = RB[12:0]; burstcount = 10'd8;
        @(posedge clk); #1; read = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); #1; rst = 1'b1;
        #1;
        chk("midrst_waitrequest", {31'b0, waitrequest}, 1);
        chk("midrst_rdvalid", {31'b0, readdatavalid}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (readdatavalid) cnt++;
        end
        chk("no_rdvalid_after_rst", cnt, 0);
        chk("rd_queue_drained", rq.size(), 0);
        exp_read(32'h0, 2'b00);
        do_read(CTRL, 1);
        exp_read(32'h0, 2'b00);
        do_read(STAT, 1);
        wbuf[0] = 32'h1234_5678;
        exp_strobe(0, 0, 32'h1234_5678);
        wq.push_back(2'b00);
        do_write(0, 1, -1, 1'b0);

        repeat (3) @(negedge clk);
        chk("strobe_queue_empty", sq.size(), 0);
        chk("read_queue_empty", rq.size(), 0);
        chk("wresp_queue_empty", wq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
